// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared WISC pipeline types and constants
package wisc_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [3:0]  HLT_OPCODE = 4'hF;
    localparam logic [15:0] PC_INC     = 16'h0002;
    localparam logic [15:0] NOP_INSTR  = 16'h0000;

endpackage

// File: rtl/addsub_16bit.sv
// rtl/addsub_16bit.sv - 16-bit modulo adder/subtractor
module addsub_16bit (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        sub_i,
    output logic [15:0] sum_o
);

    assign sum_o = sub_i ? (a_i - b_i) : (a_i + b_i);

endmodule

// File: rtl/ifid_reg.sv
// rtl/ifid_reg.sv - 33-bit IF/ID pipeline register with hold and clear-valid
module ifid_reg
    import wisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold_i,
    input  logic        clear_valid_i,
    input  logic        load_i,
    input  logic [15:0] instr_i,
    input  logic [15:0] pc_plus2_i,
    output logic [15:0] instr_o,
    output logic [15:0] pc_plus2_o,
    output logic        valid_o
);

    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_plus2_q, pc_plus2_d;
    logic        valid_q, valid_d;

    // Clear-valid wins over hold so a flush always produces a bubble.
    always_comb begin
        instr_d    = instr_q;
        pc_plus2_d = pc_plus2_q;
        valid_d    = valid_q;
        if (clear_valid_i) begin
            valid_d = 1'b0;
        end else if (!hold_i && load_i) begin
            instr_d    = instr_i;
            pc_plus2_d = pc_plus2_i;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_plus2_q <= 16'h0000;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus2_q <= pc_plus2_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus2_o = pc_plus2_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - WISC instruction fetch stage (PC, imem request, IF/ID)
// Optional perf counters: IF_FETCH_PERF_EN
module if_fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = wisc_pkg::HLT_OPCODE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic        halted
`ifdef IF_FETCH_PERF_EN
   ,output logic [15:0] perf_fetched,
    output logic [15:0] perf_wait
`endif
);

    import wisc_pkg::fetch_state_t;
    import wisc_pkg::RUN;
    import wisc_pkg::WAIT;
    import wisc_pkg::HALT;
    import wisc_pkg::PC_INC;

    fetch_state_t state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  pc_plus2;
    logic         ifid_hold, ifid_clear, ifid_load;
    logic         is_hlt;

    addsub_16bit u_pc_inc (
        .a_i   (pc_q),
        .b_i   (PC_INC),
        .sub_i (1'b0),
        .sum_o (pc_plus2)
    );

    assign is_hlt = (imem_rdata[15:12] == HLT_OPCODE);

    // Priority: redirect > stall > fetch. Responses during redirect/stall are dropped.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_hold  = 1'b0;
        ifid_clear = 1'b0;
        ifid_load  = 1'b0;
        if (redirect) begin
            pc_d       = redirect_pc;
            ifid_clear = 1'b1;
            state_d    = RUN;
        end else if (stall) begin
            ifid_hold = 1'b1;
        end else begin
            case (state_q)
                RUN, WAIT: begin
                    if (imem_ready) begin
                        ifid_load = 1'b1;
                        if (is_hlt) begin
                            state_d = HALT;
                        end else begin
                            pc_d    = pc_plus2;
                            state_d = RUN;
                        end
                    end else begin
                        ifid_clear = 1'b1;
                        state_d    = WAIT;
                    end
                end
                HALT:    ifid_clear = 1'b1;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    ifid_reg u_ifid_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .hold_i        (ifid_hold),
        .clear_valid_i (ifid_clear),
        .load_i        (ifid_load),
        .instr_i       (imem_rdata),
        .pc_plus2_i    (pc_plus2),
        .instr_o       (ifid_instr),
        .pc_plus2_o    (ifid_pc_plus2),
        .valid_o       (ifid_valid)
    );

    // Gated by rst_n so no request is visible while reset is held.
    assign imem_req  = rst_n && (state_q != HALT);
    assign imem_addr = pc_q;
    assign halted    = (state_q == HALT);

`ifdef IF_FETCH_PERF_EN
    logic [15:0] perf_fetched_q, perf_fetched_d;
    logic [15:0] perf_wait_q, perf_wait_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_wait_d    = perf_wait_q;
        if (ifid_load && !ifid_hold && !ifid_clear && (perf_fetched_q != 16'hFFFF)) begin
            perf_fetched_d = perf_fetched_q + 16'd1;
        end
        if ((state_q == WAIT) && (perf_wait_q != 16'hFFFF)) begin
            perf_wait_d = perf_wait_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= 16'h0000;
            perf_wait_q    <= 16'h0000;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_wait_q    <= perf_wait_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_wait    = perf_wait_q;
`else
    // Counters absent in this build.
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic        halted;
`ifdef IF_FETCH_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_wait;
`endif

    int          checks = 0;
    int          errors = 0;
    int          exp_fetched = 0;
    logic [15:0] exp_pc;
    logic [31:0] sb_q[$];
    logic [31:0] exp_w;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .ifid_valid    (ifid_valid),
        .halted        (halted)
`ifdef IF_FETCH_PERF_EN
       ,.perf_fetched  (perf_fetched),
        .perf_wait     (perf_wait)
`endif
    );

    task automatic drive(input logic s, input logic r, input logic [15:0] rpc,
                         input logic rdy, input logic [15:0] rd);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        imem_ready  = rdy;
        imem_rdata  = rd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch_one(input string name, input logic [15:0] word);
        checks++;
        if (imem_addr !== exp_pc) begin
            errors++;
            $display("FAIL %s_addr: got %h want %h", name, imem_addr, exp_pc);
        end
        sb_q.push_back({word, exp_pc + 16'd2});
        exp_fetched++;
        drive(1'b0, 1'b0, 16'h0000, 1'b1, word);
        exp_pc = exp_pc + 16'd2;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s_sb: got empty scoreboard want entry", name);
        end else begin
            exp_w = sb_q.pop_front();
            if ({ifid_valid, ifid_instr, ifid_pc_plus2} !== {1'b1, exp_w}) begin
                errors++;
                $display("FAIL %s_ifid: got v=%b %h/%h want v=1 %h/%h", name,
                         ifid_valid, ifid_instr, ifid_pc_plus2, exp_w[31:16], exp_w[15:0]);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        imem_ready = 1'b0; imem_rdata = 16'h0000;
        repeat (2) @(negedge clk);
        checks++;
        if ({imem_req, ifid_valid, halted, ifid_instr, ifid_pc_plus2, imem_addr} !== 51'd0) begin
            errors++;
            $display("FAIL reset_state: got req=%b v=%b h=%b %h %h addr=%h want all zero",
                     imem_req, ifid_valid, halted, ifid_instr, ifid_pc_plus2, imem_addr);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_req: got %b want 1", imem_req);
        end
        exp_pc = 16'h0000;
    endtask

    task automatic test_seq;
        fetch_one("seq0", 16'h1234);
        fetch_one("seq1", 16'h5678);
        checks++;
        if (imem_addr !== 16'h0004) begin
            errors++;
            $display("FAIL seq_next_addr: got %h want 0004", imem_addr);
        end
    endtask

    task automatic test_wait;
        drive(1'b0, 1'b1, 16'h0010, 1'b1, 16'h9999);
        exp_pc = 16'h0010;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'hDEAD);
            checks++;
            if ({imem_addr, ifid_valid} !== {exp_pc, 1'b0}) begin
                errors++;
                $display("FAIL wait_%0d: got addr=%h v=%b want addr=%h v=0", i, imem_addr, ifid_valid, exp_pc);
            end
        end
        fetch_one("wait_resume", 16'hA001);
`ifdef IF_FETCH_PERF_EN
        checks++;
        if (perf_wait !== 16'd3) begin
            errors++;
            $display("FAIL perf_wait: got %0d want 3", perf_wait);
        end
`endif
    endtask

    task automatic test_stall;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'hBEEF);
            checks++;
            if ({imem_addr, ifid_valid, ifid_instr, ifid_pc_plus2} !== {16'h0012, 1'b1, 16'hA001, 16'h0012}) begin
                errors++;
                $display("FAIL stall_%0d: got addr=%h v=%b %h/%h want addr=0012 v=1 a001/0012",
                         i, imem_addr, ifid_valid, ifid_instr, ifid_pc_plus2);
            end
        end
        fetch_one("stall_resume", 16'h2222);
    endtask

    task automatic test_redirect;
        drive(1'b1, 1'b1, 16'h0040, 1'b1, 16'h3333);
        exp_pc = 16'h0040;
        checks++;
        if ({imem_addr, ifid_valid} !== {16'h0040, 1'b0}) begin
            errors++;
            $display("FAIL redirect: got addr=%h v=%b want addr=0040 v=0", imem_addr, ifid_valid);
        end
        fetch_one("redirect_fetch", 16'h4444);
    endtask

    task automatic test_halt;
        drive(1'b0, 1'b1, 16'h0020, 1'b0, 16'h0000);
        exp_pc = 16'h0020;
        fetch_one("hlt", 16'hF000);
        exp_pc = 16'h0020;
        checks++;
        if ({halted, imem_req, imem_addr} !== {1'b1, 1'b0, 16'h0020}) begin
            errors++;
            $display("FAIL halt_enter: got h=%b req=%b addr=%h want h=1 req=0 addr=0020",
                     halted, imem_req, imem_addr);
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111);
        checks++;
        if ({halted, ifid_valid, imem_addr} !== {1'b1, 1'b0, 16'h0020}) begin
            errors++;
            $display("FAIL halt_frozen: got h=%b v=%b addr=%h want h=1 v=0 addr=0020",
                     halted, ifid_valid, imem_addr);
        end
        drive(1'b0, 1'b1, 16'h0008, 1'b0, 16'h0000);
        exp_pc = 16'h0008;
        checks++;
        if ({halted, imem_req, imem_addr, ifid_valid} !== {1'b0, 1'b1, 16'h0008, 1'b0}) begin
            errors++;
            $display("FAIL halt_resume: got h=%b req=%b addr=%h v=%b want h=0 req=1 addr=0008 v=0",
                     halted, imem_req, imem_addr, ifid_valid);
        end
        fetch_one("halt_after", 16'h5555);
    endtask

    task automatic test_wrap;
        drive(1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0000);
        exp_pc = 16'hFFFE;
        fetch_one("wrap", 16'h4321);
        checks++;
        if ({ifid_pc_plus2, imem_addr} !== 32'h0000_0000) begin
            errors++;
            $display("FAIL wrap_pc: got pc2=%h addr=%h want 0000 0000", ifid_pc_plus2, imem_addr);
        end
`ifdef IF_FETCH_PERF_EN
        checks++;
        if (perf_fetched !== exp_fetched[15:0]) begin
            errors++;
            $display("FAIL perf_fetched: got %0d want %0d", perf_fetched, exp_fetched);
        end
`endif
    endtask

    task automatic test_reset_mid_wait;
        exp_pc = 16'h0000;
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr, ifid_valid, halted, ifid_instr} !== {1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_mid_wait: got req=%b addr=%h v=%b h=%b i=%h want all zero",
                     imem_req, imem_addr, ifid_valid, halted, ifid_instr);
        end
`ifdef IF_FETCH_PERF_EN
        checks++;
        if ({perf_fetched, perf_wait} !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf: got %0d %0d want 0 0", perf_fetched, perf_wait);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        fetch_one("post_reset", 16'h7777);
    endtask

    initial begin
        test_reset;
        test_seq;
        test_wait;
        test_stall;
        test_redirect;
        test_halt;
        test_wrap;
        test_reset_mid_wait;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d entries want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
